// File: rtl/wbfml_bridge.sv
// Wishbone single-access to 4x64-bit FML burst bridge with a one-line (32-byte) read buffer.
// Read hits ack after 1 cycle; misses and writes ack 4 cycles after fml_ack; one request outstanding.
module wbfml_bridge (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [31:0] fml_adr,
  output logic        fml_stb,
  output logic        fml_we,
  input  logic        fml_ack,
  output logic [7:0]  fml_sel,
  output logic [63:0] fml_di,
  input  logic [63:0] fml_do
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RREQ   = 3'd1,
    S_RBURST = 3'd2,
    S_WREQ   = 3'd3,
    S_WBURST = 3'd4,
    S_ACK    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [26:0]       tag_q, tag_d;
  logic [3:0][63:0]  buf_q, buf_d;
  logic [31:2]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdat_q, rdat_d;

  logic req;
  logic rd_hit;
  logic wr_hit;
  logic wr_phase;
  logic unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign rd_hit     = valid_q & (tag_q == wb_adr_i[31:5]);
  assign wr_hit     = valid_q & (tag_q == adr_q[31:5]);
  assign wr_phase   = (state_q == S_WREQ) | (state_q == S_WBURST);
  assign unused_adr = ^wb_adr_i[1:0];

  // Big-endian word pick: word 0 of a beat lives in the upper half.
  function automatic logic [31:0] pick_word(input logic [3:0][63:0] b, input logic [2:0] a);
    logic [63:0] beat;
    beat = b[a[2:1]];
    return a[0] ? beat[31:0] : beat[63:32];
  endfunction

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (wb_we_i)     state_d = S_WREQ;
          else if (rd_hit) state_d = S_ACK;
          else             state_d = S_RREQ;
        end
      end
      S_RREQ:   if (fml_ack) state_d = S_RBURST;
      S_RBURST: if (cnt_q == 2'd3) state_d = S_ACK;
      S_WREQ:   if (fml_ack) state_d = S_WBURST;
      S_WBURST: if (cnt_q == 2'd3) state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FML request side is decoded straight from the state; write beat data follows the beat counter.
  always_comb begin
    fml_stb = (state_q == S_RREQ) | (state_q == S_WREQ);
    fml_we  = (state_q == S_WREQ);
    fml_adr = fml_stb ? {adr_q[31:5], 5'b0} : 32'h0;
    fml_di  = wr_phase ? {dat_q, dat_q} : 64'h0;
    fml_sel = 8'h00;
    if (wr_phase && (cnt_q == adr_q[4:3])) begin
      fml_sel = adr_q[2] ? {4'h0, sel_q} : {sel_q, 4'h0};
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    buf_d   = buf_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    rdat_d  = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d = wb_adr_i[31:2];
          dat_d = wb_dat_i;
          sel_d = wb_sel_i;
          we_d  = wb_we_i;
          if (!wb_we_i && rd_hit) begin
            ack_d  = 1'b1;
            rdat_d = pick_word(buf_q, wb_adr_i[4:2]);
          end
        end
      end
      S_RREQ: begin
        if (fml_ack) begin
          buf_d[0] = fml_do;
          cnt_d    = 2'd1;
          valid_d  = 1'b0;
        end
      end
      S_RBURST: begin
        buf_d[cnt_q] = fml_do;
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          valid_d = 1'b1;
          tag_d   = adr_q[31:5];
          ack_d   = wb_cyc_i;
          rdat_d  = wb_cyc_i ? pick_word(buf_d, adr_q[4:2]) : 32'h0;
        end
      end
      S_WREQ, S_WBURST: begin
        if ((state_q == S_WBURST) || fml_ack) begin
          cnt_d = cnt_q + 2'd1;
          // Keep the buffered line coherent with what goes out to SDRAM.
          if (wr_hit) begin
            for (int i = 0; i < 8; i++) begin
              if (fml_sel[i]) buf_d[cnt_q][i*8 +: 8] = fml_di[i*8 +: 8];
            end
          end
          if ((state_q == S_WBURST) && (cnt_q == 2'd3)) begin
            ack_d = wb_cyc_i;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      tag_q   <= 27'h0;
      buf_q   <= '0;
      adr_q   <= 30'h0;
      dat_q   <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= 32'h0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      buf_q   <= buf_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;

endmodule

// File: tb/tb_wbfml_bridge.sv
// Directed bench for wbfml_bridge with a small FML slave model (ack after 2 cycles of stb).
module tb_wbfml_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [31:0] fml_adr;
  logic        fml_stb, fml_we, fml_ack;
  logic [7:0]  fml_sel;
  logic [63:0] fml_di, fml_do;

  wbfml_bridge dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),
    .wb_ack_o(wb_ack_o),
    .fml_adr (fml_adr),
    .fml_stb (fml_stb),
    .fml_we  (fml_we),
    .fml_ack (fml_ack),
    .fml_sel (fml_sel),
    .fml_di  (fml_di),
    .fml_do  (fml_do)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FML slave: line data = base + beat, base depends on the line address.
  int          n_bursts = 0;
  int          slv_beat = 0;
  int          slv_wait = 0;
  int          a_cyc    = 0;
  logic        slv_wr   = 1'b0;
  logic [31:0] last_adr = 32'h0;
  logic        last_we  = 1'b0;
  logic [63:0] slv_base = 64'h0;
  logic [7:0]  wsel [4];
  logic [63:0] wdi  [4];

  initial begin
    fml_ack = 1'b0;
    fml_do  = 64'h0;
    forever begin
      @(posedge sys_clk);
      #2;
      fml_ack = 1'b0;
      if (sys_rst) begin
        slv_beat = 0;
        slv_wait = 0;
      end else if (slv_beat != 0) begin
        fml_do = slv_base + 64'(slv_beat);
        if (slv_wr) begin
          wsel[slv_beat] = fml_sel;
          wdi[slv_beat]  = fml_di;
        end
        slv_beat = (slv_beat == 3) ? 0 : slv_beat + 1;
      end else if (fml_stb) begin
        if (slv_wait == 1) begin
          slv_wait = 0;
          n_bursts++;
          last_adr = fml_adr;
          last_we  = fml_we;
          slv_wr   = fml_we;
          a_cyc    = cyc;
          slv_base = 64'h0011223344556677 + ({32'h0, fml_adr} << 32);
          fml_do   = slv_base;
          fml_ack  = 1'b1;
          wsel[0]  = fml_sel;
          wdi[0]   = fml_di;
          slv_beat = 1;
        end else begin
          slv_wait++;
        end
      end
    end
  end

  // One Wishbone access; returns data, start cycle and ack cycle, checks for a single-cycle ack.
  task automatic wb_xfer(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output int start_c, output int ack_c);
    logic got;
    got = 1'b0;
    rd = 32'h0;
    ack_c = 0;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    start_c = cyc;
    for (int i = 0; i < 40; i++) begin
      @(posedge sys_clk); #1;
      if (wb_ack_o) begin
        got = 1'b1;
        rd = wb_dat_o;
        ack_c = cyc;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check_eq({tag, " ack_seen"}, 64'(got), 64'd1);
    @(posedge sys_clk); #1;
    check_eq({tag, " ack_pulse"}, 64'(wb_ack_o), 64'd0);
  endtask

  logic [31:0] rd;
  int sc, ac, bb;
  logic saw_ack;

  initial begin
    sys_rst = 1'b1;
    wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("rst wb_ack_o", 64'(wb_ack_o), 64'd0);
    check_eq("rst wb_dat_o", 64'(wb_dat_o), 64'd0);
    check_eq("rst fml_stb", 64'(fml_stb), 64'd0);
    check_eq("rst fml_we", 64'(fml_we), 64'd0);
    check_eq("rst fml_adr", 64'(fml_adr), 64'd0);
    check_eq("rst fml_sel", 64'(fml_sel), 64'd0);
    check_eq("rst fml_di", fml_di, 64'd0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Cold read miss
    wb_xfer("rd00", 1'b0, 32'h00, 32'h0, 4'hF, rd, sc, ac);
    check_eq("rd00 data", 64'(rd), 64'h00112233);
    check_eq("rd00 bursts", 64'(n_bursts), 64'd1);
    check_eq("rd00 fml_adr", 64'(last_adr), 64'h00);
    check_eq("rd00 fml_we", 64'(last_we), 64'd0);
    check_eq("rd00 ack_lat", 64'(ac - a_cyc), 64'd4);

    // Hit on the last word of the line
    wb_xfer("rd1c", 1'b0, 32'h1C, 32'h0, 4'hF, rd, sc, ac);
    check_eq("rd1c data", 64'(rd), 64'h4455667A);
    check_eq("rd1c lat", 64'(ac - sc), 64'd1);
    check_eq("rd1c bursts", 64'(n_bursts), 64'd1);

    // Write-through on a buffered line
    wb_xfer("wr0c", 1'b1, 32'h0C, 32'hDEADBEEF, 4'hF, rd, sc, ac);
    check_eq("wr0c bursts", 64'(n_bursts), 64'd2);
    check_eq("wr0c fml_we", 64'(last_we), 64'd1);
    check_eq("wr0c fml_adr", 64'(last_adr), 64'h00);
    check_eq("wr0c sel0", 64'(wsel[0]), 64'h00);
    check_eq("wr0c sel1", 64'(wsel[1]), 64'h0F);
    check_eq("wr0c sel2", 64'(wsel[2]), 64'h00);
    check_eq("wr0c sel3", 64'(wsel[3]), 64'h00);
    check_eq("wr0c di1", wdi[1], 64'hDEADBEEFDEADBEEF);
    check_eq("wr0c ack_lat", 64'(ac - a_cyc), 64'd4);
    wb_xfer("rd0c", 1'b0, 32'h0C, 32'h0, 4'hF, rd, sc, ac);
    check_eq("rd0c data", 64'(rd), 64'hDEADBEEF);
    check_eq("rd0c bursts", 64'(n_bursts), 64'd2);

    // Line replacement
    wb_xfer("rd20", 1'b0, 32'h20, 32'h0, 4'hF, rd, sc, ac);
    check_eq("rd20 data", 64'(rd), 64'h00112253);
    check_eq("rd20 bursts", 64'(n_bursts), 64'd3);
    check_eq("rd20 fml_adr", 64'(last_adr), 64'h20);
    wb_xfer("rd00b", 1'b0, 32'h00, 32'h0, 4'hF, rd, sc, ac);
    check_eq("rd00b data", 64'(rd), 64'h00112233);
    check_eq("rd00b bursts", 64'(n_bursts), 64'd4);

    // Master abandons the cycle mid-burst
    wb_adr_i = 32'h40; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 20 && slv_beat < 1; i++) begin
      @(posedge sys_clk); #1;
    end
    check_eq("drop in_burst", 64'(slv_beat >= 1), 64'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk); #1;
      if (wb_ack_o) saw_ack = 1'b1;
    end
    check_eq("drop no_ack", 64'(saw_ack), 64'd0);
    check_eq("drop bursts", 64'(n_bursts), 64'd5);
    wb_xfer("rd5c", 1'b0, 32'h5C, 32'h0, 4'hF, rd, sc, ac);
    check_eq("rd5c data", 64'(rd), 64'h4455667A);
    check_eq("rd5c lat", 64'(ac - sc), 64'd1);
    check_eq("rd5c bursts", 64'(n_bursts), 64'd5);

    // Reset in the middle of a write burst
    wb_adr_i = 32'h48; wb_dat_i = 32'h12345678; wb_we_i = 1'b1; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 20 && slv_beat < 2; i++) begin
      @(posedge sys_clk); #1;
    end
    check_eq("wrst in_burst", 64'(slv_beat >= 2), 64'd1);
    sys_rst = 1'b1;
    #1;
    check_eq("wrst fml_stb", 64'(fml_stb), 64'd0);
    check_eq("wrst fml_we", 64'(fml_we), 64'd0);
    check_eq("wrst fml_adr", 64'(fml_adr), 64'd0);
    check_eq("wrst fml_sel", 64'(fml_sel), 64'd0);
    check_eq("wrst fml_di", fml_di, 64'd0);
    check_eq("wrst wb_ack_o", 64'(wb_ack_o), 64'd0);
    check_eq("wrst wb_dat_o", 64'(wb_dat_o), 64'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    bb = n_bursts;
    wb_xfer("rd40", 1'b0, 32'h40, 32'h0, 4'hF, rd, sc, ac);
    check_eq("rd40 miss", 64'(n_bursts - bb), 64'd1);
    check_eq("rd40 data", 64'(rd), 64'h00112273);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
